// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types and helpers for stream_mux_rr.
package stream_mux_pkg;
  typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_e;
  function automatic int next_rr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching from ptr+1 and wrapping modulo N.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);
  logic [SW-1:0] idx;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    idx = ptr;
    for (int i = 0; i < N; i++) begin
      idx = SW'(next_rr(int'(idx), N));
      if (!any && req[idx]) begin
        any = 1'b1;
        gnt_idx = idx;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel round-robin stream mux with a registered output stage.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);
  logic [N-1:0]  req, gnt;
  logic [SW-1:0] gnt_idx, ptr_q, ptr_d, out_sel_q, out_sel_d;
  logic          any, load, xfer;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_state_e state_q, state_d;
  // every transfer moves ptr to the granted channel, so ptr_q names the locked channel
  assign req = (state_q == ST_LOCKED) ? in_valid & (N'(1) << ptr_q) : in_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (xfer) state_d = in_last[gnt_idx] ? ST_IDLE : ST_LOCKED;
  end
`else
  assign req = in_valid;
`endif
  rr_arbiter #(.N(N)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );
  assign load = !out_valid_q || out_ready;
  assign in_ready = (rst_n && load && any) ? gnt : '0;
  assign xfer = |in_ready;
  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d = xfer ? in_data[int'(gnt_idx)*W +: W] : out_data_q;
    out_last_d = xfer ? in_last[gnt_idx] : out_last_q;
    out_sel_d = xfer ? gnt_idx : out_sel_q;
    ptr_d = xfer ? gnt_idx : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_sel_q <= '0;
      ptr_q <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_sel_q <= out_sel_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed tests for stream_mux_rr (N=4 and N=3 instances).
module tb_stream_mux_rr;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*8-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0, in_last = '0, in_ready;
  logic [7:0] out_data;
  logic out_valid, out_last, out_ready = 1'b0;
  logic [1:0] out_sel;
  logic [23:0] in_data3 = '0;
  logic [2:0] in_valid3 = '0, in_last3 = '0, in_ready3;
  logic [7:0] out_data3;
  logic out_valid3, out_last3, out_ready3 = 1'b0;
  logic [1:0] out_sel3;
  int total = 0, bad = 0;

  stream_mux_rr #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );
  stream_mux_rr #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3),
    .out_sel(out_sel3), .out_ready(out_ready3)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = '0;
    in_last = '0;
    out_ready = 1'b0;
    in_valid3 = '0;
    out_ready3 = 1'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) in_data[k*8 +: 8] = 8'(8'hA0 + k);
    cyc();
    cyc();
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_sel got=%0d exp=0", out_sel); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
    cyc();
    total++; if (out_sel !== 2'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL reset_first_beat got=sel%0d/v%b exp=sel0/v1", out_sel, out_valid); end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int k = 0; k < N; k++) in_data[k*8 +: 8] = 8'(8'hA0 + k);
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (out_sel !== 2'(i % 4) || out_data !== 8'(8'hA0 + i % 4) || out_valid !== 1'b1)
        begin bad++; $display("FAIL rotation[%0d] got=sel%0d/%h/v%b exp=sel%0d/%h/v1", i, out_sel, out_data, out_valid, i % 4, 8'(8'hA0 + i % 4)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_data[23:16] = 8'h55;
    in_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_ready0 got=%b exp=0100", in_ready); end
    cyc();
    total++; if (out_data !== 8'h55 || out_sel !== 2'd2 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%h/sel%0d/v%b exp=55/sel2/v1", out_data, out_sel, out_valid); end
    in_data[23:16] = 8'h56;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", i, in_ready); end
      cyc();
      total++; if (out_data !== 8'h55 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] got=%h/v%b exp=55/v1", i, out_data, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
    cyc();
    total++; if (out_data !== 8'h56) begin bad++; $display("FAIL bp_beat2 got=%h exp=56", out_data); end
    in_data[23:16] = 8'h57;
    cyc();
    total++; if (out_data !== 8'h57 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_beat3 got=%h/v%b exp=57/v1", out_data, out_valid); end
    in_valid = 4'b0000;
    cyc();
    total++; if (out_valid !== 1'b0 || out_data !== 8'h57) begin bad++; $display("FAIL bp_drain got=%h/v%b exp=57/v0", out_data, out_valid); end
  endtask

  task automatic test_sparse_wrap();
    int exp_sel[4] = '{0, 2, 0, 2};
    do_reset();
    for (int k = 0; k < 3; k++) in_data3[k*8 +: 8] = 8'(8'hB0 + k);
    in_valid3 = 3'b101;
    out_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (out_sel3 !== 2'(exp_sel[i]) || out_data3 !== 8'(8'hB0 + exp_sel[i]) || out_valid3 !== 1'b1)
        begin bad++; $display("FAIL sparse[%0d] got=sel%0d/%h exp=sel%0d/%h", i, out_sel3, out_data3, exp_sel[i], 8'(8'hB0 + exp_sel[i])); end
    end
    in_valid3 = '0;
  endtask

  task automatic test_pkt_lock();
    int beat;
    logic [N-1:0] acc;
`ifdef STREAM_MUX_PKT_LOCK_EN
    int exp_sel[5] = '{1, 1, 1, 0, 0};
    logic [7:0] exp_data[5] = '{8'hD1, 8'hD2, 8'hD3, 8'hC0, 8'hC0};
    logic exp_last[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    int exp_sel[5] = '{1, 0, 1, 0, 1};
    logic [7:0] exp_data[5] = '{8'hD1, 8'hC0, 8'hD2, 8'hC0, 8'hD3};
    logic exp_last[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    do_reset();
    out_ready = 1'b1;
    beat = 0;
    in_data[7:0] = 8'hC0;
    in_last[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = (i > 0);
      in_data[15:8] = 8'(8'hD1 + beat);
      in_last[1] = (beat == 2);
      in_valid[1] = (beat < 3);
      #1;
      acc = in_ready;
      cyc();
      if (acc[1]) beat++;
      total++;
      if (out_sel !== 2'(exp_sel[i]) || out_data !== exp_data[i] || out_last !== exp_last[i])
        begin bad++; $display("FAIL pkt[%0d] got=sel%0d/%h/l%b exp=sel%0d/%h/l%b", i, out_sel, out_data, out_last, exp_sel[i], exp_data[i], exp_last[i]); end
    end
    in_valid = '0;
  endtask

  task automatic test_reset_mid_packet();
    logic [N-1:0] exp_rdy;
`ifdef STREAM_MUX_PKT_LOCK_EN
    exp_rdy = 4'b0010;
`else
    exp_rdy = 4'b0001;
`endif
    do_reset();
    out_ready = 1'b1;
    in_data[7:0] = 8'hC0;
    in_data[15:8] = 8'hE1;
    in_last = 4'b0000;
    in_valid = 4'b0010;
    cyc();
    in_valid = 4'b0011;
    #1;
    total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL midpkt_ready got=%b exp=%b", in_ready, exp_rdy); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin bad++; $display("FAIL midpkt_in_reset got=v%b/%b exp=v0/0000", out_valid, in_ready); end
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL midpkt_after_ready got=%b exp=0001", in_ready); end
    cyc();
    total++; if (out_sel !== 2'd0 || out_data !== 8'hC0) begin bad++; $display("FAIL midpkt_after_beat got=sel%0d/%h exp=sel0/c0", out_sel, out_data); end
    in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_backpressure();
    test_sparse_wrap();
    test_pkt_lock();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
